// File: rtl/rx_frame_fsm_pkg.sv
// Shared UART receive definitions: FSM state enum, frame word bit positions,
// data-length encoding and a helper that maps it to the last data bit index.
package rx_frame_fsm_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StStop2
    } rx_state_e;

    // Bit positions inside the delivered frame word; [7:0] is the data.
    localparam int unsigned RXF_PERR  = 8;
    localparam int unsigned RXF_FERR  = 9;
    localparam int unsigned RXF_BRK   = 10;
    localparam int unsigned RXF_VALID = 11;

    // data_bits_i encoding.
    localparam logic [1:0] DATA_BITS_5 = 2'd0;
    localparam logic [1:0] DATA_BITS_6 = 2'd1;
    localparam logic [1:0] DATA_BITS_7 = 2'd2;
    localparam logic [1:0] DATA_BITS_8 = 2'd3;

    // Index of the last data bit (N-1) for a given data length code.
    function automatic logic [2:0] last_bit_idx(input logic [1:0] data_bits);
        return 3'd4 + {1'b0, data_bits};
    endfunction

endpackage

// File: rtl/rx_frame_fsm_if.sv
// Frame delivery bundle from the UART receiver to the receive FIFO.
//   frame_o   : packed frame word (data, parity_err, frame_err, break, valid)
//   done_flag : one-cycle strobe, high on the cycle frame_o is updated
// master = receiver side (drives), slave = FIFO side (reads).
interface rx_frame_fsm_if #(
    parameter int unsigned FRAME_W = 12
) ();
    logic [FRAME_W-1:0] frame_o;
    logic               done_flag;

    modport master (output frame_o, output done_flag);
    modport slave  (input frame_o, input done_flag);
endinterface

// File: rtl/rx_line_sync.sv
// RX line conditioning: two-flop synchronizer (both flops reset to 1, line idle
// high) and the bit sampler used by the receive FSM.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   rx_i           : raw serial line
//   baud_tick_i    : oversampling tick
//   tick_cnt_i     : current oversampling count from the FSM
//   samp_pos_i     : tick count at which the FSM takes its decision
//   rxs_o          : synchronized line
//   sample_bit_o   : value the FSM uses at the decision tick
// Build option RX_MAJORITY_VOTE_EN: sample_bit_o is the 2-of-3 majority of the
// synchronized line at the decision tick and the two ticks before it.
// Otherwise sample_bit_o is the synchronized line itself.
module rx_line_sync #(
    parameter int unsigned TickW = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             rx_i,
    input  logic             baud_tick_i,
    input  logic [TickW-1:0] tick_cnt_i,
    input  logic [TickW-1:0] samp_pos_i,
    output logic             rxs_o,
    output logic             sample_bit_o
);

    logic sync1_q, sync2_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
        end
    end

    assign rxs_o = sync2_q;

`ifdef RX_MAJORITY_VOTE_EN
    logic vote0_q, vote1_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vote0_q <= 1'b1;
            vote1_q <= 1'b1;
        end else if (baud_tick_i) begin
            if (tick_cnt_i == samp_pos_i - TickW'(2)) vote0_q <= sync2_q;
            if (tick_cnt_i == samp_pos_i - TickW'(1)) vote1_q <= sync2_q;
        end
    end

    assign sample_bit_o = (vote0_q & vote1_q) | (vote0_q & sync2_q) | (vote1_q & sync2_q);
`else
    logic unused_vote;
    assign unused_vote  = ^{baud_tick_i, tick_cnt_i, samp_pos_i};
    assign sample_bit_o = sync2_q;
`endif

endmodule

// File: rtl/rx_frame_fsm.sv
// UART receive deserializer feeding the receive FIFO. Oversamples the
// synchronized RX line on baud_tick_i, assembles 5-8 data bits with optional
// parity and 1 or 2 stop bits, and publishes a 12-bit frame word with a
// one-cycle done_flag strobe.
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   rx_i            : raw serial line (idle high, asynchronous)
//   RXen            : receiver enable; low aborts any frame in progress
//   baud_tick_i     : one-cycle pulse at OVS x baud
//   data_bits_i     : 0..3 -> 5..8 data bits
//   parity_en_i     : parity bit present
//   parity_odd_i    : 1 odd, 0 even parity
//   stop2_i         : two stop bits
//   rx_busy_o       : high whenever the FSM is not idle
//   fifo_if         : frame_o / done_flag towards the FIFO
// Build option RX_MAJORITY_VOTE_EN selects 3-sample majority voting per bit.
module rx_frame_fsm
    import rx_frame_fsm_pkg::*;
#(
    parameter int unsigned OVS     = 16,
    parameter int unsigned FRAME_W = 12
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_i,
    input  logic       RXen,
    input  logic       baud_tick_i,
    input  logic [1:0] data_bits_i,
    input  logic       parity_en_i,
    input  logic       parity_odd_i,
    input  logic       stop2_i,
    output logic       rx_busy_o,
    rx_frame_fsm_if.master fifo_if
);

    localparam int unsigned TickW = $clog2(OVS);

    // Voting needs the tick after mid-bit, so decisions land one tick later.
`ifdef RX_MAJORITY_VOTE_EN
    localparam logic [TickW-1:0] StartPos = TickW'(OVS / 2);
`else
    localparam logic [TickW-1:0] StartPos = TickW'(OVS / 2 - 1);
`endif
    // The counter is cleared at the start-bit decision, so one bit later is OVS-1.
    localparam logic [TickW-1:0] BitPos = TickW'(OVS - 1);

    rx_state_e          state_q;
    logic [TickW-1:0]   tick_cnt_q;
    logic [2:0]         bit_cnt_q;
    logic [7:0]         shift_q;
    logic [1:0]         data_bits_q;
    logic               parity_en_q, parity_odd_q, stop2_q;
    logic               perr_q, ferr_q, zero_q;
    logic               arm_q;
    logic [FRAME_W-1:0] frame_q;
    logic               done_q;

    logic               rxs, sample_bit, sample_now;
    logic [TickW-1:0]   samp_pos;
    logic [2:0]         align_sh;
    logic [FRAME_W-1:0] frame_d;

    assign samp_pos   = (state_q == StStart) ? StartPos : BitPos;
    assign sample_now = baud_tick_i && (state_q != StIdle) && (tick_cnt_q == samp_pos);
    assign align_sh   = 3'd3 - {1'b0, data_bits_q};

    rx_line_sync #(
        .TickW (TickW)
    ) u_line_sync (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .rx_i         (rx_i),
        .baud_tick_i  (baud_tick_i),
        .tick_cnt_i   (tick_cnt_q),
        .samp_pos_i   (samp_pos),
        .rxs_o        (rxs),
        .sample_bit_o (sample_bit)
    );

    // Frame word as it would be published on the current stop-bit sample.
    always_comb begin
        frame_d            = '0;
        frame_d[7:0]       = shift_q >> align_sh;
        frame_d[RXF_PERR]  = perr_q;
        frame_d[RXF_FERR]  = ferr_q | ~sample_bit;
        frame_d[RXF_BRK]   = zero_q & ~sample_bit;
        frame_d[RXF_VALID] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            tick_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            data_bits_q  <= DATA_BITS_8;
            parity_en_q  <= 1'b0;
            parity_odd_q <= 1'b0;
            stop2_q      <= 1'b0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            zero_q       <= 1'b0;
            arm_q        <= 1'b1;
            frame_q      <= '0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // A new start needs the line to have been high since a frame ended
            // on a low stop bit, so a held break yields a single frame.
            if (rxs) arm_q <= 1'b1;

            if (!RXen) begin
                state_q    <= StIdle;
                tick_cnt_q <= '0;
                bit_cnt_q  <= '0;
            end else begin
                if (state_q != StIdle && baud_tick_i) tick_cnt_q <= tick_cnt_q + TickW'(1);

                case (state_q)
                    StIdle: begin
                        if (!rxs && arm_q) begin
                            state_q      <= StStart;
                            tick_cnt_q   <= '0;
                            bit_cnt_q    <= '0;
                            shift_q      <= '0;
                            data_bits_q  <= data_bits_i;
                            parity_en_q  <= parity_en_i;
                            parity_odd_q <= parity_odd_i;
                            stop2_q      <= stop2_i;
                            perr_q       <= 1'b0;
                            ferr_q       <= 1'b0;
                            zero_q       <= 1'b1;
                        end
                    end
                    StStart: begin
                        if (sample_now) begin
                            if (sample_bit) begin
                                state_q <= StIdle;
                            end else begin
                                tick_cnt_q <= '0;
                                state_q    <= StData;
                            end
                        end
                    end
                    StData: begin
                        if (sample_now) begin
                            shift_q <= {sample_bit, shift_q[7:1]};
                            zero_q  <= zero_q & ~sample_bit;
                            if (bit_cnt_q == last_bit_idx(data_bits_q)) begin
                                bit_cnt_q <= '0;
                                state_q   <= parity_en_q ? StParity : StStop;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 3'd1;
                            end
                        end
                    end
                    StParity: begin
                        if (sample_now) begin
                            perr_q  <= ((^shift_q) ^ sample_bit) != parity_odd_q;
                            zero_q  <= zero_q & ~sample_bit;
                            state_q <= StStop;
                        end
                    end
                    StStop, StStop2: begin
                        if (sample_now) begin
                            ferr_q <= ferr_q | ~sample_bit;
                            zero_q <= zero_q & ~sample_bit;
                            if (stop2_q && state_q == StStop) begin
                                state_q <= StStop2;
                            end else begin
                                frame_q <= frame_d;
                                done_q  <= 1'b1;
                                state_q <= StIdle;
                                if (!sample_bit) arm_q <= 1'b0;
                            end
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign rx_busy_o         = (state_q != StIdle);
    assign fifo_if.frame_o   = frame_q;
    assign fifo_if.done_flag = done_q;

endmodule

// File: tb/tb_rx_frame_fsm.sv
// Directed bench for rx_frame_fsm: baud tick every second clock (OVS=16, so a
// bit lasts 32 clocks), frames driven bit by bit, published frames recorded by
// a monitor and compared against hand-computed words.
module tb_rx_frame_fsm;

    localparam int BitClk = 32;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic       rxen;
    logic       baud_tick;
    logic [1:0] data_bits;
    logic       par_en, par_odd, stop2;
    logic       busy;

    int         assert_cnt = 0;
    int         fail_cnt   = 0;
    int         done_cnt   = 0;
    int         dbl_cnt    = 0;
    int         exp_done   = 0;
    logic       prev_done  = 1'b0;
    logic [11:0] frames_seen [64];

    rx_frame_fsm_if #(.FRAME_W(12)) fifo_if ();

    rx_frame_fsm #(
        .OVS     (16),
        .FRAME_W (12)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .rx_i         (rx),
        .RXen         (rxen),
        .baud_tick_i  (baud_tick),
        .data_bits_i  (data_bits),
        .parity_en_i  (par_en),
        .parity_odd_i (par_odd),
        .stop2_i      (stop2),
        .rx_busy_o    (busy),
        .fifo_if      (fifo_if)
    );

    always #5 clk = ~clk;

    initial begin
        baud_tick = 1'b0;
        forever begin
            @(negedge clk);
            baud_tick = ~baud_tick;
        end
    end

    // Records every published frame and flags strobes longer than one clock.
    always @(negedge clk) begin
        if (fifo_if.done_flag === 1'b1) begin
            if (done_cnt < 64) frames_seen[done_cnt] = fifo_if.frame_o;
            done_cnt++;
            if (prev_done) dbl_cnt++;
        end
        prev_done = fifo_if.done_flag;
    end

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        assert_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives bits[0] first, one bit time each, then returns the line to idle.
    task automatic send_bits(input logic [31:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            rx = bits[i];
            repeat (BitClk) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_frame(input string tag, input logic [11:0] exp);
        exp_done++;
        check({tag, "_count"}, 12'(done_cnt), 12'(exp_done));
        check({tag, "_frame"}, frames_seen[(exp_done - 1) % 64], exp);
    endtask

    initial begin
        rst_n     = 1'b0;
        rx        = 1'b1;
        rxen      = 1'b1;
        data_bits = 2'd3;
        par_en    = 1'b0;
        par_odd   = 1'b0;
        stop2     = 1'b0;
        idle(2);
        check("reset_frame", fifo_if.frame_o, 12'h000);
        check("reset_done", 12'(fifo_if.done_flag), 12'h000);
        check("reset_busy", 12'(busy), 12'h000);
        rst_n = 1'b1;
        idle(4);

        // 8N1 0xA5, with start-edge latency checked on the way in.
        rx = 1'b0;
        idle(2);
        check("start_lat_2clk", 12'(busy), 12'h000);
        idle(1);
        check("start_lat_3clk", 12'(busy), 12'h001);
        idle(BitClk - 3);
        send_bits({23'h0, 1'b1, 8'hA5}, 9);
        idle(BitClk);
        check_frame("8n1_a5", 12'h8A5);
        check("8n1_busy_after", 12'(busy), 12'h000);

        // 7E, 0x35 with the parity bit wrong (four ones, sent parity 1).
        data_bits = 2'd2; par_en = 1'b1; par_odd = 1'b0;
        send_bits({22'h0, 1'b1, 1'b1, 7'h35, 1'b0}, 10);
        idle(BitClk);
        check_frame("7e_bad_par", 12'h935);

        // 5O, 0x13 with correct odd parity 0; checks right-justification.
        data_bits = 2'd0; par_odd = 1'b1;
        send_bits({24'h0, 1'b1, 1'b0, 5'h13, 1'b0}, 8);
        idle(BitClk);
        check_frame("5o_ok", 12'h813);

        // 8N2, second stop bit low.
        data_bits = 2'd3; par_en = 1'b0; par_odd = 1'b0; stop2 = 1'b1;
        send_bits({21'h0, 1'b0, 1'b1, 8'h5A, 1'b0}, 11);
        idle(BitClk);
        check_frame("8n2_ferr", 12'hA5A);

        // Line held low for 12 bit times: a single break frame.
        stop2 = 1'b0;
        rx = 1'b0;
        idle(12 * BitClk);
        rx = 1'b1;
        idle(2 * BitClk);
        check_frame("break", 12'hE00);
        idle(2 * BitClk);
        check("break_no_repeat", 12'(done_cnt), 12'(exp_done));

        // 4-tick low glitch in idle: false start.
        rx = 1'b0;
        idle(4);
        check("glitch_busy_hi", 12'(busy), 12'h001);
        idle(4);
        rx = 1'b1;
        idle(2 * BitClk);
        check("glitch_busy_lo", 12'(busy), 12'h000);
        check("glitch_no_done", 12'(done_cnt), 12'(exp_done));

`ifdef RX_MAJORITY_VOTE_EN
        // 0x55 with a one-tick low glitch in the middle of data bit 0.
        rx = 1'b0;
        idle(BitClk);
        rx = 1'b1;
        idle(15);
        rx = 1'b0;
        idle(2);
        rx = 1'b1;
        idle(15);
        send_bits({24'h0, 1'b1, 7'h2A}, 8);
        idle(BitClk);
        check_frame("vote_55", 12'h855);
`endif

        // Back-to-back 8N1 frames 0x12 then 0x34, no idle gap.
        send_bits({12'h0, 1'b1, 8'h34, 1'b0, 1'b1, 8'h12, 1'b0}, 20);
        idle(BitClk);
        exp_done++;
        check("b2b_first", frames_seen[(exp_done - 1) % 64], 12'h812);
        check_frame("b2b_second", 12'h834);

        // RXen dropped mid-DATA, then 0x3C received normally.
        send_bits(32'h0, 4);
        rx = 1'b0;
        check("rxen_busy_before", 12'(busy), 12'h001);
        rxen = 1'b0;
        idle(1);
        check("rxen_busy_abort", 12'(busy), 12'h000);
        rx = 1'b1;
        idle(2 * BitClk);
        rxen = 1'b1;
        idle(BitClk);
        check("rxen_no_done", 12'(done_cnt), 12'(exp_done));
        send_bits({22'h0, 1'b1, 8'h3C, 1'b0}, 10);
        idle(BitClk);
        check_frame("rxen_3c", 12'h83C);

        // Asynchronous reset in the middle of a frame.
        rx = 1'b0;
        idle(80);
        check("rst_busy_before", 12'(busy), 12'h001);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_frame", fifo_if.frame_o, 12'h000);
        check("rst_mid_done", 12'(fifo_if.done_flag), 12'h000);
        check("rst_mid_busy", 12'(busy), 12'h000);
        rx = 1'b1;
        idle(3);
        rst_n = 1'b1;
        idle(BitClk);
        send_bits({22'h0, 1'b1, 8'hC3, 1'b0}, 10);
        idle(BitClk);
        check_frame("post_rst_c3", 12'h8C3);

        check("done_one_clk", 12'(dbl_cnt), 12'h000);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/rx_frame_fsm.md
# rx_frame_fsm

UART receive deserializer sitting directly upstream of the receive FIFO. Synchronizes the serial RX line and samples it at 16x oversampling from the baud generator tick. Assembles 5–8 data bits with optional parity and 1 or 2 stop bits, and hands each completed frame plus error flags to the FIFO as a 12-bit word with a one-cycle `done_flag` strobe.

## Interface
- `OVS`, 16: oversampling ticks per bit; must be a power of two ≥ 8.
- `FRAME_W`, 12: width of the frame word delivered to the FIFO.
- `clk_i`  in  1  system clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `rx_i`  in  1  raw serial line; idle high; asynchronous to `clk_i`.
- `RXen`  in  1  receiver enable.
- `baud_tick_i`  in  1  one-`clk_i` pulse at OVS × baud rate.
- `data_bits_i`  in  2  data length: 0=5, 1=6, 2=7, 3=8 bits.
- `parity_en_i`  in  1  parity bit present.
- `parity_odd_i`  in  1  1 = odd parity, 0 = even parity.
- `stop2_i`  in  1  two stop bits.
- `frame_o`  out  12  packed frame, feeds FIFO `rd_data_i`:
  - [7:0] data, LSB first on the line, unused MSBs 0.
  - [8] parity_err.
  - [9] frame_err.
  - [10] break.
  - [11] valid, always 1 in a delivered frame.
- `done_flag`  out  1  one-cycle strobe when `frame_o` is updated.
- `rx_busy_o`  out  1  high in any state other than IDLE.

## Operation
- Two-flop synchronizer on `rx_i`, both flops reset to 1. All decisions use the synchronized line `rxs`.
- Counters:
  - `tick_cnt`: log2(OVS) bits; advances only on `baud_tick_i`.
  - `bit_cnt`: 3 bits.
  - `shift`: 8-bit shift register, LSB-first.
- State machine:
  - IDLE → START when `rxs` is 0 and RXen is 1. On entry, clear `tick_cnt` and latch `data_bits_i`, `parity_en_i`, `parity_odd_i` and `stop2_i` for the whole frame.
  - START: at tick OVS/2−1, sample the line. If 1, treat as a false start and return to IDLE with no strobe. If 0, clear `tick_cnt` and go to DATA.
  - DATA: sample at mid-bit (tick OVS−1 after the start-bit mid-sample). Shift the bit into MSB, then increment `bit_cnt`. After the last data bit:
    - go to PARITY if parity is enabled;
    - otherwise go to STOP.
  - PARITY: sample the parity bit. Set parity_err when the XOR of the data bits and the parity bit is not equal to `parity_odd`.
  - STOP: sample the stop bit. A 0 sets frame_err.
    - With stop2 and the first stop bit done, go to STOP2 (same rule).
    - Otherwise, publish the frame and go to IDLE.
- Data alignment: right-justify the data into [7:0] by shifting down by 8−N.
- Break: set when the data, the parity bit (if present) and all stop bits sampled 0.
- Publish: register `frame_o` and pulse `done_flag` on the same edge. `frame_o` holds until the next publish.
- RXen low in any state: force IDLE, clear counters, `done_flag` 0. `frame_o` holds its value; the partial frame is discarded.
- Reset, asynchronous: state IDLE, `frame_o` 0, `done_flag` 0, `rx_busy_o` 0, counters 0, `shift` 0.

## Timing
- Start edge to START entry: 3 clk (2 synchronizer flops plus 1 state register).
- `done_flag` asserts 1 clk after the `baud_tick_i` that samples the last stop bit. It is high for exactly 1 clk.
- Back-to-back frames are supported: after publish in IDLE, a new start edge is accepted the next cycle. A start 1/2 bit after the stop mid-sample is received without loss.
- `baud_tick_i` arriving on the same cycle as the IDLE→START transition is not counted.
- A `baud_tick_i` while RXen is low is ignored.
- Sustained throughput with 8N1: one frame per 10 × OVS ticks.

## Configuration
- `RX_MAJORITY_VOTE_EN` defined: every sample (start, data, parity, stop) is the 2-of-3 majority of `rxs` at ticks OVS/2−2, OVS/2−1 and OVS/2. A single-tick glitch at mid-bit is rejected.
- Not defined: single sample at tick OVS/2−1. The vote registers are not instantiated.

## Structure
- Shared UART package holds:
  - the state enum `rx_state_e` (IDLE, START, DATA, PARITY, STOP, STOP2);
  - frame bit-index constants `RXF_PERR=8`, `RXF_FERR=9`, `RXF_BRK=10`, `RXF_VALID=11`;
  - the `data_bits_i` encoding.
- One natural sub-module: `rx_line_sync`. It holds the 2-flop synchronizer plus the optional majority-vote sampler and outputs `rxs` and `sample_bit`.

## Test plan
- 8N1, OVS=16, byte 0xA5 → one `done_flag` pulse; `frame_o` = 0x8A5; `rx_busy_o` low 1 clk after.
- 7 data bits, even parity, byte 0x35 sent with a wrong parity bit → `frame_o` = 0x935 (valid plus parity_err).
- 8N2, second stop bit driven 0 → `frame_o[9]` = 1, data correct.
- Line held low for 12 bit times → one frame, `frame_o` = 0xE00 (valid, frame_err, break). No further strobe until the line returns high and a new start edge occurs.
- A 4-tick low glitch in IDLE → false start, no `done_flag`, back to IDLE. With `RX_MAJORITY_VOTE_EN`, a 1-tick mid-bit glitch inside 0x55 still yields 0x855.
- RXen dropped mid-DATA, then re-raised and 0x3C sent → no strobe for the aborted frame, then `frame_o` = 0x83C. `rst_ni` pulsed mid-frame → all outputs 0 immediately.
